// File: rtl/avalon_bus_arbiter_pkg.sv
// arb_pkg: shared arbiter state encoding, port ids and counter sizing
package arb_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT_I, ARB_GRANT_D} arb_state_t;
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;
  function automatic int cnt_width(input int n);
    return n > 0 ? $clog2(n + 1) : 1;
  endfunction
endpackage

// File: rtl/avalon_bus_arbiter_timeout_counter.sv
// bus_timeout_counter: counts stalled cycles of one transfer and flags when the limit is reached
module bus_timeout_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         expired
);
  logic [W-1:0] count;
  assign expired = (limit != '0) && (count == limit);
  // saturates at the limit; a zero limit keeps the count parked at zero
  always_ff @(posedge clk or negedge reset)
    if (!reset) count <= '0;
    else if (clear) count <= '0;
    else if (enable && count != limit) count <= count + 1'b1;
endmodule

// File: rtl/avalon_bus_arbiter.sv
// avalon_bus_arbiter: round-robin I/D arbiter onto one Avalon-MM master with stall timeout
module avalon_bus_arbiter
  import arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter bit TIE_FIRST_D    = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_address,
  input  logic        i_read,
  output logic        i_waitrequest,
  output logic [31:0] i_readdata,
  input  logic [31:0] d_address,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_writedata,
  input  logic [3:0]  d_byteenable,
  output logic        d_waitrequest,
  output logic [31:0] d_readdata,
  output logic [31:0] m_address,
  output logic        m_read,
  output logic        m_write,
  output logic [31:0] m_writedata,
  output logic [3:0]  m_byteenable,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  output logic        grant_d,
  output logic        timeout_err
);
  localparam int CW = cnt_width(TIMEOUT_CYCLES);
  arb_state_t  state, state_d;
  logic        last_served, last_d;
  logic [31:0] addr_d, wdata_d;
  logic        rd_d, wr_d, err_d;
  logic [3:0]  be_d;
  logic        i_req, d_req, in_grant, owner, expired, timeout_now, done, go, port;
  assign i_req         = i_read;
  assign d_req         = d_read | d_write;
  assign in_grant      = state != ARB_IDLE;
  assign owner         = state == ARB_GRANT_D ? PORT_D : PORT_I;
  assign timeout_now   = in_grant & m_waitrequest & expired;
  assign done          = in_grant & (~m_waitrequest | timeout_now);
  assign port          = in_grant ? ~owner : (i_req & d_req) ? ~last_served : d_req;
  assign go            = in_grant ? done & (owner == PORT_D ? i_req : d_req) : i_req | d_req;
  assign i_waitrequest = ~(done & owner == PORT_I);
  assign d_waitrequest = ~(done & owner == PORT_D);
  assign i_readdata    = timeout_now ? '0 : m_readdata;
  assign d_readdata    = timeout_now ? '0 : m_readdata;
  assign grant_d       = state == ARB_GRANT_D;
  bus_timeout_counter #(.W(CW)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (done | ~in_grant),
    .enable  (in_grant & m_waitrequest),
    .limit   (CW'(TIMEOUT_CYCLES)),
    .expired (expired)
  );
  // next grant and command: completion frees the bus, a pending request claims it on the same edge
  always_comb begin
    state_d = state;
    last_d  = last_served;
    addr_d  = m_address;
    rd_d    = m_read;
    wr_d    = m_write;
    wdata_d = m_writedata;
    be_d    = m_byteenable;
    err_d   = timeout_err | timeout_now;
    if (done) begin
      state_d = ARB_IDLE;
      last_d  = owner;
      rd_d    = 1'b0;
      wr_d    = 1'b0;
    end
    if (go) begin
      state_d = port == PORT_D ? ARB_GRANT_D : ARB_GRANT_I;
      addr_d  = port == PORT_D ? d_address : i_address;
      rd_d    = port == PORT_D ? d_read : 1'b1;
      wr_d    = port == PORT_D & d_write;
      wdata_d = port == PORT_D ? d_writedata : m_writedata;
      be_d    = port == PORT_D ? d_byteenable : 4'hF;
    end
  end
  // registered command keeps the downstream bus stable for the whole transfer
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state        <= ARB_IDLE;
      last_served  <= TIE_FIRST_D ? PORT_I : PORT_D;
      m_address    <= '0;
      m_read       <= 1'b0;
      m_write      <= 1'b0;
      m_writedata  <= '0;
      m_byteenable <= '0;
      timeout_err  <= 1'b0;
    end else begin
      state        <= state_d;
      last_served  <= last_d;
      m_address    <= addr_d;
      m_read       <= rd_d;
      m_write      <= wr_d;
      m_writedata  <= wdata_d;
      m_byteenable <= be_d;
      timeout_err  <= err_d;
    end
endmodule
